fp_max_abs_reduce: RTL and testbench
====================================

Name: fp_max_abs_reduce

Overview:
Streaming reduction that finds the largest-magnitude element of a frame of IEEE-754 style floats, one element per clock. It generalises the two-operand single-precision max-abs compare to parametrised exponent and mantissa widths and arbitrary frame length. It also tracks the index of the winner, carries NaN/Inf classification and the element count, and uses valid/ready handshakes on both sides. It sits after vector datapaths, for example for normalisation or pivot selection, as a drop-in reducer.

Parameters:
EXP_W, 8, exponent width in bits
MAN_W, 23, mantissa (fraction) width in bits
IDX_W, 16, width of element index and count
W, 1+EXP_W+MAN_W (derived localparam), element width

Ports:
clk  in  1  clock, rising edge
rstn  in  1  asynchronous active-low reset
in_valid  in  1  input element valid
in_ready  out  1  block can accept an element
in_data  in  W  element {sign, exp, man}
in_last  in  1  marks final element of frame
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_mag  out  W  winning magnitude, bit W-1 forced 0
out_sign  out  1  original sign of winner
out_idx  out  IDX_W  zero-based frame index of winner
out_count  out  IDX_W  number of elements in frame, saturating
out_nan  out  1  winner is NaN
out_ovf  out  1  frame exceeded 2^IDX_W-1 elements

Behaviour:
- Clock is clk. Reset is rstn, asynchronous and active-low. All state clears immediately on assertion.
- Reset values: out_valid=0, out_mag=0, out_sign=0, out_idx=0, out_count=0, out_nan=0, out_ovf=0. Internal running max is 0, index counter is 0, FSM is IDLE.
- Reset mid-frame discards the partial frame. The first beat after release starts a new frame at index 0.
- Beat accepted when in_valid && in_ready.
- in_ready = !out_valid || out_ready. This is combinational from registered out_valid and the out_ready input. There is no combinational path from in_valid to in_ready.
- FSM states:
  - IDLE: no frame open. An accepted beat loads the running max unconditionally, sets idx=0, count=1, and moves to ACCUM. If in_last is also set, the FSM moves to the result state instead.
  - ACCUM: each accepted beat is compared against the running max and increments count. An accepted beat with in_last produces the result.
  - Result: out_valid=1 is held until out_ready, then the FSM returns to IDLE.
  - If out_ready and a new accepted first beat occur in the same cycle, the result pops and the new frame loads in the same cycle, giving zero bubble.
- Latency: the result registers are updated on the edge that accepts the in_last beat, so out_valid rises the following cycle. Result fields are stable while out_valid=1 && !out_ready.
- Magnitude compare ignores the sign bit:
  - Unsigned compare on {exp, man}.
  - The candidate wins only if strictly greater, so on ties the earlier index wins.
  - +0 and -0 tie.
- NaN (exp all-ones, man != 0) beats everything, including Inf. Once a NaN is held, later elements, including later NaNs, never displace it. out_nan=1, out_mag is the NaN payload with the sign cleared, and out_idx is the first NaN's index.
- Inf (exp all-ones, man == 0) beats all finite values and ties with another Inf, so the first one wins.
- Denormals are compared as ordinary bit patterns, which gives correct ordering.
- Index and count:
  - Index counter increments per accepted beat.
  - count saturates at 2^IDX_W-1. out_ovf is set when a beat is accepted while count is already saturated.
  - Once ovf is set, winner index updates are frozen, but the compare continues and out_mag remains correct.
- in_valid with in_ready=0 has no effect. The producer must hold data stable, standard AXI-stream rule.

Decomposition:
- Shared package fp_pkg holds:
  - EXP_W/MAN_W default localparams for single precision (8/23) and half precision (5/10).
  - Functions fp_is_nan, fp_is_inf and fp_mag_gt(a,b), all parametrised via package-level parameters or passed widths.
  - FSM state enum {IDLE, ACCUM, RESULT}.
- One sub-module, fp_mag_cmp: combinational compare of two W-bit operands returning cand_wins plus nan/inf flags. Shared with future min-abs and argmin blocks.
- Top level holds FSM, counters, running max registers and the handshake.

Test Plan:
- Single precision, frame [0x3F800000 (1.0), 0xC0000000 (-2.0), 0x40000000 (2.0) last], out_ready=1 -> one cycle after the last beat: out_mag=0x40000000, out_sign=1, out_idx=1, out_count=3, out_nan=0.
- Single-beat frame 0xBF000000 (-0.5) with in_last -> out_valid next cycle: out_mag=0x3F000000, out_sign=1, idx=0, count=1.
- Frame [0x7F800000 (+Inf), 0x7FC00000 (NaN), 0x7FC00001 (NaN) last] -> out_nan=1, out_mag=0x7FC00000, idx=1, count=3.
- Backpressure: out_ready=0 for 5 cycles after result -> in_ready=0 and result stable. Then out_ready=1 together with a new first beat -> old result pops and new frame starts in the same cycle, no lost beat.
- Reset: assert rstn=0 after 2 beats of a 4-beat frame -> all outputs 0 immediately. After release, frame [0x00000000, 0x80000000 last] -> out_mag=0, sign=0, idx=0 (tie keeps first).
- IDX_W=3, frame of 9 beats with max at beat 8 -> out_count=7, out_ovf=1, out_mag correct, out_idx holds the pre-overflow winner.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared floating-point helpers for magnitude reductions (max-abs, min-abs,
// argmin style blocks).
//
// Contents:
//   SP_/HP_ EXP_W/MAN_W : default field widths for single and half precision
//   fsm_state_e         : frame FSM states shared by the reducers
//   fp_is_nan           : exponent all-ones and mantissa non-zero
//   fp_is_inf           : exponent all-ones and mantissa zero
//   fp_mag_gt(a, b)     : unsigned compare of {exp, man}, sign ignored
//
// Operands are passed zero-extended to 64 bits, along with the field widths,
// so one set of functions serves every parametrisation with
// 1 + EXP_W + MAN_W <= 64.
package fp_pkg;

  localparam int unsigned SP_EXP_W = 8;
  localparam int unsigned SP_MAN_W = 23;
  localparam int unsigned HP_EXP_W = 5;
  localparam int unsigned HP_MAN_W = 10;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    RESULT
  } fsm_state_e;

  // Extract an unsigned bit field [lsb +: width] from v; width must be < 64.
  function automatic logic [63:0] fp_field(input logic [63:0]   v,
                                           input int unsigned lsb,
                                           input int unsigned width);
    logic [63:0] mask;
    mask = (64'd1 << width) - 64'd1;
    return (v >> lsb) & mask;
  endfunction

  function automatic logic fp_is_nan(input logic [63:0]   v,
                                     input int unsigned exp_w,
                                     input int unsigned man_w);
    logic [63:0] ones;
    ones = (64'd1 << exp_w) - 64'd1;
    return (fp_field(v, man_w, exp_w) == ones) && (fp_field(v, 0, man_w) != 64'd0);
  endfunction

  function automatic logic fp_is_inf(input logic [63:0]   v,
                                     input int unsigned exp_w,
                                     input int unsigned man_w);
    logic [63:0] ones;
    ones = (64'd1 << exp_w) - 64'd1;
    return (fp_field(v, man_w, exp_w) == ones) && (fp_field(v, 0, man_w) == 64'd0);
  endfunction

  // IEEE encodings order correctly by magnitude as plain unsigned integers
  // once the sign is removed: denormals < normals < Inf < NaN payloads.
  function automatic logic fp_mag_gt(input logic [63:0]   a,
                                     input logic [63:0]   b,
                                     input int unsigned exp_w,
                                     input int unsigned man_w);
    return fp_field(a, 0, exp_w + man_w) > fp_field(b, 0, exp_w + man_w);
  endfunction

endpackage

// File: rtl/fp_mag_cmp.sv
// Combinational magnitude compare of two floats {sign, exp, man}.
//
// Ports:
//   cand_i      : incoming candidate element
//   held_i      : currently held element
//   cand_wins_o : candidate strictly larger in magnitude and held is not NaN
//   cand_nan_o  : candidate is NaN
//   cand_inf_o  : candidate is +/-Inf
//   held_nan_o  : held element is NaN
//   held_inf_o  : held element is +/-Inf
//
// Strictly-greater means ties (including +0/-0 and Inf/Inf) keep the held
// element. A NaN candidate needs no special case: its {exp, man} pattern is
// above every non-NaN pattern, so the unsigned compare already makes it win.
// A held NaN is never displaced, not even by a larger NaN payload.
module fp_mag_cmp
  import fp_pkg::*;
#(
  parameter int unsigned EXP_W = SP_EXP_W,
  parameter int unsigned MAN_W = SP_MAN_W,
  localparam int unsigned W    = 1 + EXP_W + MAN_W
) (
  input  logic [W-1:0] cand_i,
  input  logic [W-1:0] held_i,
  output logic         cand_wins_o,
  output logic         cand_nan_o,
  output logic         cand_inf_o,
  output logic         held_nan_o,
  output logic         held_inf_o
);

  logic [63:0] cand_x;
  logic [63:0] held_x;

  always_comb begin
    cand_x      = 64'(cand_i);
    held_x      = 64'(held_i);
    cand_nan_o  = fp_is_nan(cand_x, EXP_W, MAN_W);
    cand_inf_o  = fp_is_inf(cand_x, EXP_W, MAN_W);
    held_nan_o  = fp_is_nan(held_x, EXP_W, MAN_W);
    held_inf_o  = fp_is_inf(held_x, EXP_W, MAN_W);
    cand_wins_o = !held_nan_o && fp_mag_gt(cand_x, held_x, EXP_W, MAN_W);
  end

endmodule

// File: rtl/fp_max_abs_reduce.sv
// Streaming max-abs reducer: one float per clock, one result per frame.
//
// Ports:
//   clk, rstn           : rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready   : input handshake; in_ready = !out_valid || out_ready
//   in_data             : element {sign, exp, man}
//   in_last             : final element of the frame
//   out_valid/out_ready : result handshake; result held stable while stalled
//   out_mag             : winning {exp, man} with the sign bit cleared
//   out_sign            : original sign of the winner
//   out_idx             : zero-based frame index of the winner
//   out_count           : elements in the frame, saturating at 2^IDX_W-1
//   out_nan             : winner is NaN
//   out_ovf             : frame ran past 2^IDX_W-1 elements
//
// The running max registers track the open frame; a separate set of result
// registers is loaded on the edge accepting the in_last beat, so a new frame
// can start while the previous result is being popped (zero bubble).
module fp_max_abs_reduce
  import fp_pkg::*;
#(
  parameter int unsigned EXP_W = SP_EXP_W,
  parameter int unsigned MAN_W = SP_MAN_W,
  parameter int unsigned IDX_W = 16,
  localparam int unsigned W    = 1 + EXP_W + MAN_W
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_mag,
  output logic             out_sign,
  output logic [IDX_W-1:0] out_idx,
  output logic [IDX_W-1:0] out_count,
  output logic             out_nan,
  output logic             out_ovf
);

  localparam logic [IDX_W-1:0] CNT_MAX = '1;

  fsm_state_e state_q, state_d;

  // Running state of the open frame.
  logic [W-2:0]     run_mag_q, run_mag_d;
  logic             run_sign_q, run_sign_d;
  logic [IDX_W-1:0] run_idx_q, run_idx_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             run_nan_d;

  // Result registers presented on the output port.
  logic [W-2:0]     res_mag_q;
  logic             res_sign_q;
  logic [IDX_W-1:0] res_idx_q;
  logic [IDX_W-1:0] res_cnt_q;
  logic             res_nan_q;
  logic             res_ovf_q;

  logic accept;
  logic first_beat;
  logic cnt_sat;
  logic cand_wins, cand_nan, cand_inf, held_nan, held_inf;

  fp_mag_cmp #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W)
  ) u_cmp (
    .cand_i      (in_data),
    .held_i      ({1'b0, run_mag_q}),
    .cand_wins_o (cand_wins),
    .cand_nan_o  (cand_nan),
    .cand_inf_o  (cand_inf),
    .held_nan_o  (held_nan),
    .held_inf_o  (held_inf)
  );

  assign out_valid  = (state_q == RESULT);
  assign in_ready   = !out_valid || out_ready;
  assign accept     = in_valid && in_ready;
  // Outside ACCUM any accepted beat opens a new frame; in RESULT this only
  // happens together with out_ready, i.e. the pop and the load share a cycle.
  assign first_beat = (state_q != ACCUM);
  assign cnt_sat    = (cnt_q == CNT_MAX);

  assign out_mag   = {1'b0, res_mag_q};
  assign out_sign  = res_sign_q;
  assign out_idx   = res_idx_q;
  assign out_count = res_cnt_q;
  assign out_nan   = res_nan_q;
  assign out_ovf   = res_ovf_q;

  // Running max / index / count update.
  always_comb begin
    run_mag_d  = run_mag_q;
    run_sign_d = run_sign_q;
    run_idx_d  = run_idx_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    run_nan_d  = held_nan;
    if (accept) begin
      if (first_beat) begin
        run_mag_d  = in_data[W-2:0];
        run_sign_d = in_data[W-1];
        run_idx_d  = '0;
        cnt_d      = IDX_W'(1);
        ovf_d      = 1'b0;
        run_nan_d  = cand_nan;
      end else begin
        if (cand_wins) begin
          run_mag_d  = in_data[W-2:0];
          run_sign_d = in_data[W-1];
          run_nan_d  = cand_nan;
          // Until saturation the count before this beat is its index; once
          // saturated the index is no longer representable and stays frozen.
          if (!cnt_sat) begin
            run_idx_d = cnt_q;
          end
        end
        if (cnt_sat) begin
          ovf_d = 1'b1;
        end else begin
          cnt_d = cnt_q + IDX_W'(1);
        end
      end
    end
  end

  // Frame FSM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = in_last ? RESULT : ACCUM;
        end
      end
      ACCUM: begin
        if (accept && in_last) begin
          state_d = RESULT;
        end
      end
      RESULT: begin
        if (out_ready) begin
          if (accept) begin
            state_d = in_last ? RESULT : ACCUM;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      run_mag_q  <= '0;
      run_sign_q <= 1'b0;
      run_idx_q  <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      run_mag_q  <= run_mag_d;
      run_sign_q <= run_sign_d;
      run_idx_q  <= run_idx_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      res_mag_q  <= '0;
      res_sign_q <= 1'b0;
      res_idx_q  <= '0;
      res_cnt_q  <= '0;
      res_nan_q  <= 1'b0;
      res_ovf_q  <= 1'b0;
    end else if (accept && in_last) begin
      res_mag_q  <= run_mag_d;
      res_sign_q <= run_sign_d;
      res_idx_q  <= run_idx_d;
      res_cnt_q  <= cnt_d;
      res_nan_q  <= run_nan_d;
      res_ovf_q  <= ovf_d;
    end
  end

  // A held NaN or a held Inf tied by another Inf must never be displaced.
  a_held_kept : assert property (@(posedge clk) disable iff (!rstn)
    !(cand_wins && (held_nan || (held_inf && cand_inf))));

endmodule

// File: tb/tb_fp_max_abs_reduce.sv
module tb_fp_max_abs_reduce;

  typedef struct {
    logic [31:0] mag;
    logic        sign;
    int unsigned idx;
    int unsigned count;
    logic        nan;
    logic        ovf;
  } res_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  // Main instance: single precision, IDX_W = 16.
  logic        in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
  logic [31:0] in_data = '0;
  logic        in_ready, out_valid, out_sign, out_nan, out_ovf;
  logic [31:0] out_mag;
  logic [15:0] out_idx, out_count;

  // Small instance: IDX_W = 3 for count saturation / overflow.
  logic        s_in_valid = 1'b0, s_in_last = 1'b0, s_out_ready = 1'b1;
  logic [31:0] s_in_data = '0;
  logic        s_in_ready, s_out_valid, s_out_sign, s_out_nan, s_out_ovf;
  logic [31:0] s_out_mag;
  logic [2:0]  s_out_idx, s_out_count;

  fp_max_abs_reduce #(.EXP_W(8), .MAN_W(23), .IDX_W(16)) u_dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_mag(out_mag), .out_sign(out_sign),
    .out_idx(out_idx), .out_count(out_count), .out_nan(out_nan), .out_ovf(out_ovf)
  );

  fp_max_abs_reduce #(.EXP_W(8), .MAN_W(23), .IDX_W(3)) u_small (
    .clk(clk), .rstn(rstn), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_data(s_in_data), .in_last(s_in_last), .out_valid(s_out_valid),
    .out_ready(s_out_ready), .out_mag(s_out_mag), .out_sign(s_out_sign),
    .out_idx(s_out_idx), .out_count(s_out_count), .out_nan(s_out_nan), .out_ovf(s_out_ovf)
  );

  int   checks = 0;
  int   errors = 0;
  res_t exp_q[$];
  logic [31:0] frame[$];
  logic rand_ready = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic is_nan32(input logic [31:0] v);
    return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
  endfunction

  // Winner: first NaN if any; else first element of largest magnitude.
  // Reported index is the last winner whose position is below 2^idxw-1.
  function automatic res_t model(input logic [31:0] beats[$], input int unsigned idxw);
    res_t r;
    int unsigned maxc = (32'd1 << idxw) - 1;
    int unsigned best = 0;
    int unsigned rep  = 0;
    for (int unsigned i = 1; i < beats.size(); i++) begin
      logic better;
      if (is_nan32(beats[best]))      better = 1'b0;
      else if (is_nan32(beats[i]))    better = 1'b1;
      else                            better = (beats[i][30:0] > beats[best][30:0]);
      if (better) begin
        best = i;
        if (i < maxc) rep = i;
      end
    end
    r.mag   = {1'b0, beats[best][30:0]};
    r.sign  = beats[best][31];
    r.idx   = rep;
    r.count = (beats.size() > maxc) ? maxc : beats.size();
    r.nan   = is_nan32(beats[best]);
    r.ovf   = (beats.size() > maxc);
    return r;
  endfunction

  function automatic res_t mk(input logic [31:0] mag, input logic sign, input int unsigned idx,
                              input int unsigned count, input logic nan, input logic ovf);
    res_t r;
    r.mag = mag; r.sign = sign; r.idx = idx; r.count = count; r.nan = nan; r.ovf = ovf;
    return r;
  endfunction

  task automatic cmp_res(input string name, input res_t got, input res_t req);
    chk({name, "_mag"},   64'(got.mag),   64'(req.mag));
    chk({name, "_sign"},  64'(got.sign),  64'(req.sign));
    chk({name, "_idx"},   64'(got.idx),   64'(req.idx));
    chk({name, "_count"}, 64'(got.count), 64'(req.count));
    chk({name, "_nan"},   64'(got.nan),   64'(req.nan));
    chk({name, "_ovf"},   64'(got.ovf),   64'(req.ovf));
  endtask

  function automatic res_t dut_res();
    return mk(out_mag, out_sign, 32'(out_idx), 32'(out_count), out_nan, out_ovf);
  endfunction

  // ---------------- compare process ----------------
  res_t held;
  logic held_v = 1'b0;
  always @(negedge clk) begin
    if (!rstn) begin
      held_v = 1'b0;
    end else begin
      res_t e;
      chk("in_ready_rule", 64'(in_ready), 64'(!out_valid || out_ready));
      if (held_v) begin
        chk("stall_valid", 64'(out_valid), 64'd1);
        cmp_res("stall", dut_res(), held);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          cmp_res("result", dut_res(), e);
        end
      end
      held_v = out_valid && !out_ready;
      held   = dut_res();
    end
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #1 out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- drivers ----------------
  task automatic send_beat(input logic [31:0] d, input logic last);
    logic acc = 1'b0;
    int   n = 0;
    in_valid = 1'b1; in_data = d; in_last = last;
    while (!acc) begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1;
      n++;
      if (!acc && n > 200) begin
        chk("accept_timeout", 64'd0, 64'd1);
        break;
      end
    end
    in_valid = 1'b0; in_last = 1'b0;
    if (acc) begin
      frame.push_back(d);
      if (last) begin
        exp_q.push_back(model(frame, 16));
        frame.delete();
        chk("latency_valid", 64'(out_valid), 64'd1);
      end
    end
  endtask

  task automatic run_directed(input string name, input logic [31:0] beats[$], input res_t lit);
    cmp_res({name, "_model"}, model(beats, 16), lit);
    for (int unsigned i = 0; i < beats.size(); i++) send_beat(beats[i], i == beats.size() - 1);
  endtask

  task automatic drain();
    int n = 0;
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk); #1; n++;
    end
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  function automatic logic [31:0] rand_elem();
    logic s;
    s = 1'($urandom);
    case ($urandom_range(0, 7))
      0:       return {s, 8'hFF, 23'd0};
      1:       return {s, 8'hFF, 23'($urandom_range(1, 8))};
      2:       return {s, 31'd0};
      3:       return {s, 8'd0, 23'($urandom)};
      4, 5: begin
        case ($urandom_range(0, 3))
          0:       return {s, 31'h3F800000};
          1:       return {s, 31'h40000000};
          2:       return {s, 31'h00000001};
          default: return {s, 31'h7F7FFFFF};
        endcase
      end
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL global_timeout at %0t", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] b[$];
    logic [31:0] sb[$];
    res_t sm;

    // Reset values (checked while reset is asserted).
    #1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    cmp_res("rst", dut_res(), mk(32'h0, 1'b0, 0, 0, 1'b0, 1'b0));
    repeat (2) @(posedge clk);
    @(negedge clk); rstn = 1'b1;
    @(posedge clk); #1;

    b = '{32'h3F800000, 32'hC0000000, 32'h40000000};
    run_directed("mix", b, mk(32'h40000000, 1'b1, 1, 3, 1'b0, 1'b0));
    b = '{32'hBF000000};
    run_directed("single", b, mk(32'h3F000000, 1'b1, 0, 1, 1'b0, 1'b0));
    b = '{32'h7F800000, 32'h7FC00000, 32'h7FC00001};
    run_directed("nan", b, mk(32'h7FC00000, 1'b0, 1, 3, 1'b1, 1'b0));
    drain();

    // Backpressure, then pop and new first beat in the same cycle.
    out_ready = 1'b0;
    send_beat(32'h3F800000, 1'b0);
    send_beat(32'hC0400000, 1'b1);
    repeat (5) begin
      @(negedge clk);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send_beat(32'h40800000, 1'b0);
    chk("zero_bubble_popped", 64'(out_valid), 64'd0);
    chk("zero_bubble_q", 64'(exp_q.size()), 64'd0);
    send_beat(32'h3F800000, 1'b1);
    drain();

    // Reset mid-frame.
    send_beat(32'h40000000, 1'b0);
    send_beat(32'h40400000, 1'b0);
    #3 rstn = 1'b0;
    #1;
    frame.delete();
    chk("midrst_valid", 64'(out_valid), 64'd0);
    cmp_res("midrst", dut_res(), mk(32'h0, 1'b0, 0, 0, 1'b0, 1'b0));
    @(negedge clk); rstn = 1'b1;
    @(posedge clk); #1;
    b = '{32'h00000000, 32'h80000000};
    run_directed("zero_tie", b, mk(32'h0, 1'b0, 0, 2, 1'b0, 1'b0));
    drain();

    // Randomized frames with gaps and random backpressure.
    rand_ready = 1'b1;
    for (int f = 0; f < 150; f++) begin
      int len = $urandom_range(1, 12);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
        end
        send_beat(rand_elem(), i == len - 1);
      end
    end
    drain();

    // Overflow on the IDX_W = 3 instance: 9 beats, max at beat 8.
    sb = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h40000000, 32'h3F800000,
           32'h3F800000, 32'h3F800000, 32'h40000000, 32'h41000000};
    sm = model(sb, 3);
    cmp_res("ovf_model", sm, mk(32'h41000000, 1'b0, 3, 7, 1'b0, 1'b1));
    for (int i = 0; i < 9; i++) begin
      s_in_valid = 1'b1; s_in_data = sb[i]; s_in_last = (i == 8);
      @(negedge clk);
      chk("s_in_ready", 64'(s_in_ready), 64'd1);
      @(posedge clk); #1;
    end
    s_in_valid = 1'b0; s_in_last = 1'b0;
    chk("s_valid", 64'(s_out_valid), 64'd1);
    cmp_res("ovf", mk(s_out_mag, s_out_sign, 32'(s_out_idx), 32'(s_out_count), s_out_nan, s_out_ovf), sm);
    repeat (2) @(posedge clk);
    #1;
    chk("s_popped", 64'(s_out_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
